irq_scheduler: RTL and testbench
================================

IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 The block SHALL have parameter W_DIR, default 10, meaning the width of the program-memory address.
REQ-002 The block SHALL have parameter VEC_BASE, default 10'h3C0, meaning the vector address of source 0.
REQ-003 The block SHALL have parameter VEC_STRIDE, default 16, meaning the address distance between consecutive source vectors.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of SERVICE cycles before a forced abort.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port irq_req, input, 4 bits: level request lines; bit0 exception, bit1 port, bit2 syscall, bit3 timer.
REQ-008 The block SHALL have port mask_we, input, 1 bit: write strobe for the mask register.
REQ-009 The block SHALL have port mask_in, input, 4 bits: new mask value; 1 = source enabled.
REQ-010 The block SHALL have port cpu_ready, input, 1 bit: CPU is at an instruction boundary and may be redirected.
REQ-011 The block SHALL have port s_finish_interr, input, 1 bit: handler-return strobe from the control unit.
REQ-012 The block SHALL have port s_interruption, output, 1 bit: one-cycle redirect pulse to the PC mux select.
REQ-013 The block SHALL have port dir_vector, output, W_DIR bits: handler address, valid while s_interruption is high.
REQ-014 The block SHALL have port active_id, output, 2 bits: index of the source in service.
REQ-015 The block SHALL have port busy, output, 1 bit: high in GRANT and SERVICE.
REQ-016 The block SHALL have port pending, output, 4 bits: latched, not-yet-serviced requests.
REQ-017 The block SHALL have port mask_out, output, 4 bits: current mask register.
REQ-018 The block SHALL have port timeout_err, output, 1 bit: sticky flag set by a service abort.

Function
REQ-019 The block SHALL register irq_req each cycle and set pending[i] on a detected 0->1 edge of irq_req[i].
REQ-020 When a set and a clear of the same pending bit coincide, the set SHALL win.
REQ-021 The mask SHALL load mask_in on the cycle after mask_we=1; masked sources SHALL still latch pending but never be granted.
REQ-022 The FSM SHALL have exactly the states IDLE, GRANT and SERVICE.
REQ-023 IDLE->GRANT SHALL occur when (pending & mask) != 0 and cpu_ready=1; the winner is the lowest set index (bit0 highest priority).
REQ-024 On IDLE->GRANT, active_id SHALL take the winner index and pending[winner] SHALL clear in the same edge.
REQ-025 In GRANT, s_interruption SHALL be 1 for exactly one cycle, and dir_vector SHALL equal (VEC_BASE + active_id*VEC_STRIDE) mod 2^W_DIR.
REQ-026 The next state after GRANT SHALL always be SERVICE.
REQ-027 In SERVICE, a 10-bit counter SHALL increment each cycle from 0.
REQ-028 SERVICE->IDLE SHALL occur on s_finish_interr=1.
REQ-029 SERVICE->IDLE SHALL also occur when the counter reaches TIMEOUT, in which case timeout_err is set.
REQ-030 Requests arriving during GRANT or SERVICE SHALL only latch; there is no nesting or preemption.
REQ-031 s_finish_interr in IDLE or GRANT SHALL be ignored.
REQ-032 The minimum spacing between two s_interruption pulses SHALL be 3 cycles (GRANT, SERVICE with immediate finish, IDLE).
REQ-033 Outside GRANT, dir_vector SHALL hold its last value and s_interruption SHALL be 0.
REQ-034 timeout_err SHALL clear only on reset.

Reset
REQ-035 With reset=0, asynchronously: state=IDLE, pending=0, mask=4'hF, active_id=0, dir_vector=0, s_interruption=0, busy=0, counter=0, timeout_err=0, irq_req history=0.
REQ-036 If reset is asserted mid-SERVICE, the in-flight interrupt SHALL be dropped without a retry.
REQ-037 After reset deasserts, irq_req lines already high SHALL NOT be taken as edges until they fall and rise again.

Verification
REQ-038 Scenario: irq_req=4'b1000, cpu_ready=1 -> s_interruption pulses 1 cycle, active_id=3, dir_vector=10'h3F0, pending=0.
REQ-039 Scenario: irq_req bits 1 and 3 rise on the same cycle -> id 1 is served first (dir 10'h3D0); after finish, id 3 is served (10'h3F0).
REQ-040 Scenario: mask_in=4'b1110 written, then bit0 rises -> pending=4'b0001 and no grant; mask_in=4'hF written -> grant with id 0, dir 10'h3C0.
REQ-041 Scenario: grant with no s_finish_interr for 255 SERVICE cycles -> return to IDLE, timeout_err=1, busy=0.
REQ-042 Scenario: bit2 rises during SERVICE of id 0 -> no second pulse until finish, then grant id 2 at dir 10'h3E0.
REQ-043 Scenario: reset=0 during SERVICE with pending=4'b0100 -> all outputs return to reset values and no grant follows while irq_req stays high.

Source files
------------

// File: rtl/irq_scheduler.sv
// Four-source priority interrupt scheduler: latches request edges, grants the lowest
// enabled index at an instruction boundary and tracks the handler until it returns or times out.
module irq_scheduler #(
  parameter int               W_DIR      = 10,
  parameter logic [W_DIR-1:0] VEC_BASE   = 10'h3C0,
  parameter int               VEC_STRIDE = 16,
  parameter int               TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       irq_req,
  input  logic             mask_we,
  input  logic [3:0]       mask_in,
  input  logic             cpu_ready,
  input  logic             s_finish_interr,
  output logic             s_interruption,
  output logic [W_DIR-1:0] dir_vector,
  output logic [1:0]       active_id,
  output logic             busy,
  output logic [3:0]       pending,
  output logic [3:0]       mask_out,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, SERVICE} state_t;

  localparam logic [W_DIR-1:0] STRIDE   = W_DIR'(VEC_STRIDE);
  localparam logic [9:0]       CNT_LAST = 10'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] irq_prev;
  logic       armed;
  logic [9:0] cnt;
  logic [3:0] rise, elig, clr;
  logic [1:0] win;
  logic       take;

  // armed stays low for the first cycle after reset so lines already high
  // are absorbed into the history instead of being seen as edges
  assign rise = armed ? (irq_req & ~irq_prev) : 4'b0000;
  assign elig = pending & mask_out;
  assign take = (state == IDLE) && (elig != 4'b0000) && cpu_ready;

  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (elig[i]) win = 2'(i);
  end

  always_comb begin
    clr = 4'b0000;
    if (take) clr[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= 4'b0000;
      armed    <= 1'b0;
      pending  <= 4'b0000;
      mask_out <= 4'hF;
    end else begin
      irq_prev <= irq_req;
      armed    <= 1'b1;
      pending  <= (pending & ~clr) | rise;
      if (mask_we) mask_out <= mask_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      active_id      <= 2'd0;
      dir_vector     <= '0;
      s_interruption <= 1'b0;
      busy           <= 1'b0;
      cnt            <= 10'd0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_interruption <= 1'b0;
          if (take) begin
            state          <= GRANT;
            active_id      <= win;
            dir_vector     <= VEC_BASE + W_DIR'(win) * STRIDE;
            s_interruption <= 1'b1;
            busy           <= 1'b1;
          end
        end
        GRANT: begin
          state          <= SERVICE;
          s_interruption <= 1'b0;
          cnt            <= 10'd0;
        end
        SERVICE: begin
          cnt <= cnt + 10'd1;
          if (s_finish_interr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          s_interruption <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler; expected grants go into a scoreboard queue
// when requests are driven and are popped when the redirect pulse appears.
module tb_irq_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_req;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       cpu_ready;
  logic       s_finish_interr;
  logic       s_interruption;
  logic [9:0] dir_vector;
  logic [1:0] active_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] mask_out;
  logic       timeout_err;

  irq_scheduler dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .mask_we(mask_we), .mask_in(mask_in),
    .cpu_ready(cpu_ready), .s_finish_interr(s_finish_interr), .s_interruption(s_interruption),
    .dir_vector(dir_vector), .active_id(active_id), .busy(busy), .pending(pending),
    .mask_out(mask_out), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [9:0] dir;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pulse_cnt = 0;
  int   cyc = 0;
  int   last_pulse = 0;

  always @(posedge clk) begin
    cyc++;
    if (s_interruption === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] id, input logic [9:0] dir);
    exp_t e;
    e.id = id;
    e.dir = dir;
    sb.push_back(e);
  endtask

  // returns at the negedge where the pulse is visible (DUT in GRANT)
  task automatic wait_pulse(input string tag);
    bit   got = 0;
    exp_t e;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_interruption === 1'b1) got = 1;
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      last_pulse = cyc;
      check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_id"}, 32'(active_id), 32'(e.id));
        check({tag, "_dir"}, 32'(dir_vector), 32'(e.dir));
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic finish_service();
    @(negedge clk);
    s_finish_interr = 1'b1;
    @(negedge clk);
    s_finish_interr = 1'b0;
  endtask

  initial begin
    int p0, n, gap_start;
    reset = 1'b0;
    irq_req = 4'b0000;
    mask_we = 1'b0;
    mask_in = 4'h0;
    cpu_ready = 1'b1;
    s_finish_interr = 1'b0;
    tick(3);
    check("rst_sint", 32'(s_interruption), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_mask", 32'(mask_out), 32'hF);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_dir", 32'(dir_vector), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    tick(2);

    // single timer source
    irq_req = 4'b1000;
    push(2'd3, 10'h3F0);
    wait_pulse("timer");
    check("timer_pending", 32'(pending), 32'd0);
    tick();
    check("timer_pulse_width", 32'(s_interruption), 32'd0);
    check("timer_service_busy", 32'(busy), 32'd1);
    s_finish_interr = 1'b1;
    tick();
    s_finish_interr = 1'b0;
    check("timer_done_busy", 32'(busy), 32'd0);
    irq_req = 4'b0000;
    tick(2);

    // simultaneous port + timer: priority order and minimum pulse spacing
    irq_req = 4'b1010;
    push(2'd1, 10'h3D0);
    push(2'd3, 10'h3F0);
    wait_pulse("pri_first");
    check("pri_pending", 32'(pending), 32'b1000);
    gap_start = last_pulse;
    finish_service();
    wait_pulse("pri_second");
    check("pri_spacing", 32'(last_pulse - gap_start), 32'd3);
    finish_service();
    irq_req = 4'b0000;
    tick(2);

    // masked source latches but is not granted until re-enabled
    mask_we = 1'b1;
    mask_in = 4'b1110;
    tick();
    mask_we = 1'b0;
    check("mask_loaded", 32'(mask_out), 32'b1110);
    p0 = pulse_cnt;
    irq_req = 4'b0001;
    tick(4);
    check("mask_pending", 32'(pending), 32'b0001);
    check("mask_no_grant", 32'(pulse_cnt), 32'(p0));
    check("mask_idle", 32'(busy), 32'd0);
    mask_we = 1'b1;
    mask_in = 4'hF;
    push(2'd0, 10'h3C0);
    tick();
    mask_we = 1'b0;
    wait_pulse("unmask");
    finish_service();
    irq_req = 4'b0000;
    tick(2);

    // finish strobe while idle is ignored
    s_finish_interr = 1'b1;
    tick(2);
    s_finish_interr = 1'b0;
    check("idle_finish_busy", 32'(busy), 32'd0);

    // service timeout
    irq_req = 4'b1000;
    push(2'd3, 10'h3F0);
    wait_pulse("tmo");
    check("tmo_err_before", 32'(timeout_err), 32'd0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    check("tmo_service_cycles", 32'(n), 32'd255);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    irq_req = 4'b0000;
    tick(2);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // request during service waits for the finish, no nesting
    irq_req = 4'b0001;
    push(2'd0, 10'h3C0);
    wait_pulse("nest_first");
    tick();
    p0 = pulse_cnt;
    irq_req = 4'b0101;
    tick(4);
    check("nest_no_preempt", 32'(pulse_cnt), 32'(p0));
    check("nest_pending", 32'(pending), 32'b0100);
    push(2'd2, 10'h3E0);
    finish_service();
    wait_pulse("nest_second");
    finish_service();
    irq_req = 4'b0000;
    tick(2);

    // reset in the middle of service
    irq_req = 4'b0001;
    push(2'd0, 10'h3C0);
    wait_pulse("rst_mid");
    tick();
    irq_req = 4'b0101;
    tick();
    check("rst_mid_pending_before", 32'(pending), 32'b0100);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_pending", 32'(pending), 32'd0);
    check("rst_mid_id", 32'(active_id), 32'd0);
    check("rst_mid_dir", 32'(dir_vector), 32'd0);
    check("rst_mid_terr", 32'(timeout_err), 32'd0);
    check("rst_mid_mask", 32'(mask_out), 32'hF);
    tick();
    reset = 1'b1;
    p0 = pulse_cnt;
    tick(10);
    check("rst_mid_no_grant", 32'(pulse_cnt), 32'(p0));
    check("rst_mid_no_latch", 32'(pending), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
